// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_arb_pkg
// Description : Shared types and constants for the multiplier arbiter:
//               FSM state encoding, timeout substitute result and the
//               width of the completed-operation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HUNG  = 3'd4
  } state_e;

  // Result returned to a requester whose operation timed out (quiet NaN)
  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  // Width of the saturating completed-operation counter
  localparam int C_OPCNT_W = 16;

endpackage : mul_arb_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Returns the first set
//               request at or after the pointer (wrapping) as a one-hot
//               grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Candidate index, one bit wider so ptr+k never overflows before the wrap
  logic [IDX_W:0] w_cand;

  // Scan requesters starting at the pointer; the first hit wins
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any_o && req_i[w_cand[IDX_W-1:0]]) begin
        any_o                      = 1'b1;
        idx_o                      = w_cand[IDX_W-1:0];
        grant_o[w_cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter
// Description : Round-robin arbiter sharing one single-precision multiplier
//               (ready/done handshake) among NUM_REQ requesters. Operands
//               are latched for the whole operation, results are returned
//               on a shared bus with a one-hot done strobe, and a watchdog
//               substitutes a quiet NaN and locks up if the multiplier hangs.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_op1,
  input  logic [32*NUM_REQ-1:0] req_op2,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    resp_done,
  output logic [31:0]           resp_res,
  output logic                  resp_err,
  output logic                  mul_ready,
  output logic [31:0]           mul_op1,
  output logic [31:0]           mul_op2,
  input  logic [31:0]           mul_res,
  input  logic                  mul_done,
  output logic                  hung,
  output logic [C_OPCNT_W-1:0]  op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [15:0]            wd_q;
  logic [NUM_REQ-1:0]     req_ack_q;
  logic [NUM_REQ-1:0]     resp_done_q;
  logic [31:0]            resp_res_q;
  logic                   resp_err_q;
  logic                   mul_ready_q;
  logic [31:0]            mul_op1_q;
  logic [31:0]            mul_op2_q;
  logic                   hung_q;
  logic [C_OPCNT_W-1:0]   op_count_q;

  logic [IDX_W-1:0]       ptr_d;
  logic [16:0]            wd_d;
  logic [C_OPCNT_W-1:0]   op_count_d;

  logic                   w_any;
  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_gidx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .any_o   (w_any),
    .grant_o (w_grant),
    .idx_o   (w_gidx)
  );

  // Next pointer, watchdog increment and saturating counter increment
  always_comb begin
    ptr_d      = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
    wd_d       = {1'b0, wd_q} + 17'd1;
    op_count_d = (op_count_q == '1) ? op_count_q : op_count_q + 1'b1;
  end

  // Arbiter FSM; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      wd_q        <= '0;
      req_ack_q   <= '0;
      resp_done_q <= '0;
      resp_res_q  <= '0;
      resp_err_q  <= 1'b0;
      mul_ready_q <= 1'b0;
      mul_op1_q   <= '0;
      mul_op2_q   <= '0;
      hung_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      // Single-cycle strobes drop unless re-asserted below
      req_ack_q   <= '0;
      mul_ready_q <= 1'b0;
      resp_done_q <= '0;
      resp_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A multiplier still showing done from the last operation must
          // clear before a new start pulse, or it could be mistaken for
          // completion of the next one.
          if (w_any && !mul_done) begin
            gidx_q      <= w_gidx;
            grant_q     <= w_grant;
            mul_op1_q   <= req_op1[32*int'(w_gidx) +: 32];
            mul_op2_q   <= req_op2[32*int'(w_gidx) +: 32];
            req_ack_q   <= w_grant;
            mul_ready_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ptr_q   <= ptr_d;
          wd_q    <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            resp_res_q  <= mul_res;
            resp_done_q <= grant_q;
            op_count_q  <= op_count_d;
            state_q     <= ST_RESP;
          end else if (wd_d == 17'(TIMEOUT)) begin
            resp_res_q  <= C_QNAN;
            resp_err_q  <= 1'b1;
            resp_done_q <= grant_q;
            hung_q      <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wd_q <= wd_d[15:0];
          end
        end
        ST_RESP: begin
          state_q <= hung_q ? ST_HUNG : ST_IDLE;
        end
        ST_HUNG: begin
          state_q <= ST_HUNG;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign resp_done = resp_done_q;
  assign resp_res  = resp_res_q;
  assign resp_err  = resp_err_q;
  assign mul_ready = mul_ready_q;
  assign mul_op1   = mul_op1_q;
  assign mul_op2   = mul_op2_q;
  assign hung      = hung_q;
  assign op_count  = op_count_q;

endmodule : mul_arbiter
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arbiter
// Description : Directed self-checking bench for mul_arbiter with a simple
//               behavioural multiplier (table of known products, settable
//               latency, done hold time and a never-completes mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    resp_done;
  logic [31:0]           resp_res;
  logic                  resp_err;
  logic                  mul_ready;
  logic [31:0]           mul_op1;
  logic [31:0]           mul_op2;
  logic [31:0]           mul_res;
  logic                  mul_done;
  logic                  hung;
  logic [15:0]           op_count;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  int model_delay = 2;
  int model_hold  = 0;
  bit model_hang  = 1'b0;

  // Per-requester operands and hand-computed IEEE754 products
  logic [31:0] op1_tab  [NUM_REQ] = '{32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40800000};
  logic [31:0] op2_tab  [NUM_REQ] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'hC0800000};
  logic [31:0] prod_tab [NUM_REQ] = '{32'h40400000, 32'h40C00000, 32'h40000000, 32'hC1800000};

  mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ack   (req_ack),
    .resp_done (resp_done),
    .resp_res  (resp_res),
    .resp_err  (resp_err),
    .mul_ready (mul_ready),
    .mul_op1   (mul_op1),
    .mul_op2   (mul_op2),
    .mul_res   (mul_res),
    .mul_done  (mul_done),
    .hung      (hung),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: products come from the table of known operand pairs
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (a == op1_tab[i] && b == op2_tab[i]) r = prod_tab[i];
    end
    return r;
  endfunction

  // Behavioural multiplier: done rises model_delay cycles after the start
  // pulse and stays high for model_hold further cycles
  initial begin : mul_model
    int          cnt;
    int          hold;
    logic [31:0] a;
    logic [31:0] b;
    cnt = 0; hold = 0; a = '0; b = '0;
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; hold = 0; mul_done = 1'b0;
      end else if (mul_ready) begin
        cnt = model_delay; a = mul_op1; b = mul_op2; mul_done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !model_hang) begin
          mul_done = 1'b1;
          mul_res  = fmul_ref(a, b);
          hold     = model_hold;
        end
      end else if (mul_done) begin
        if (hold > 0) hold--;
        else mul_done = 1'b0;
      end
    end
  end

  task automatic set_req(input int i);
    req_op1[32*i +: 32] = op1_tab[i];
    req_op2[32*i +: 32] = op2_tab[i];
    req_valid[i]        = 1'b1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    model_hang  = 1'b0;
    model_hold  = 0;
    model_delay = 2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (req_ack == '0 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_done == '0 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ack, resp_done, resp_err, mul_ready, hung} !== '0)
      $display("FAIL reset_ctrl: got %b want 0", {req_ack, resp_done, resp_err, mul_ready, hung});
    else passes++;
    checks++;
    if ({resp_res, op_count} !== '0)
      $display("FAIL reset_res_cnt: got res=%h cnt=%0d want 0/0", resp_res, op_count);
    else passes++;
    checks++;
    if ({mul_op1, mul_op2} !== '0)
      $display("FAIL reset_ops: got %h %h want 0 0", mul_op1, mul_op2);
    else passes++;
  endtask

  task automatic test_single();
    int t_ack;
    do_reset();
    model_delay = 3;
    set_req(2);
    @(negedge clk);
    t_ack = cyc;
    checks++;
    if (req_ack !== 4'b0100 || mul_ready !== 1'b1)
      $display("FAIL single_ack: got ack=%b rdy=%b want 0100/1", req_ack, mul_ready);
    else passes++;
    checks++;
    if (mul_op1 !== 32'h3F800000 || mul_op2 !== 32'h40000000)
      $display("FAIL single_ops: got %h %h want 3f800000 40000000", mul_op1, mul_op2);
    else passes++;
    req_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ack !== '0 || mul_ready !== 1'b0)
      $display("FAIL single_pulse: got ack=%b rdy=%b want 0000/0", req_ack, mul_ready);
    else passes++;
    wait_resp();
    checks++;
    if (cyc - t_ack !== 4)
      $display("FAIL single_latency: got %0d want 4", cyc - t_ack);
    else passes++;
    checks++;
    if (resp_done !== 4'b0100 || resp_res !== 32'h40000000 || resp_err !== 1'b0)
      $display("FAIL single_resp: got done=%b res=%h err=%b want 0100/40000000/0", resp_done, resp_res, resp_err);
    else passes++;
    checks++;
    if (op_count !== 16'd1)
      $display("FAIL single_count: got %0d want 1", op_count);
    else passes++;
    @(negedge clk);
    checks++;
    if (resp_done !== '0 || resp_res !== 32'h40000000)
      $display("FAIL single_hold: got done=%b res=%h want 0000/40000000", resp_done, resp_res);
    else passes++;
  endtask

  task automatic test_all4();
    logic [NUM_REQ-1:0] exp_oh;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i);
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_oh = 4'b0001 << k;
      wait_ack();
      checks++;
      if (req_ack !== exp_oh)
        $display("FAIL all4_grant%0d: got %b want %b", k, req_ack, exp_oh);
      else passes++;
      req_valid[k] = 1'b0;
      wait_resp();
      checks++;
      if (resp_done !== exp_oh || resp_res !== prod_tab[k])
        $display("FAIL all4_resp%0d: got done=%b res=%h want %b/%h", k, resp_done, resp_res, exp_oh, prod_tab[k]);
      else passes++;
    end
    checks++;
    if (op_count !== 16'd4)
      $display("FAIL all4_count: got %0d want 4", op_count);
    else passes++;
  endtask

  task automatic test_alternate();
    int                 e;
    logic [NUM_REQ-1:0] exp_oh;
    do_reset();
    model_delay = 1;
    set_req(0);
    set_req(1);
    for (int k = 0; k < 4; k++) begin
      e      = k % 2;
      exp_oh = 4'b0001 << e;
      wait_ack();
      checks++;
      if (req_ack !== exp_oh || mul_op1 !== op1_tab[e])
        $display("FAIL alt_grant%0d: got ack=%b op1=%h want %b/%h", k, req_ack, mul_op1, exp_oh, op1_tab[e]);
      else passes++;
      wait_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_done_hold();
    int t_r;
    do_reset();
    model_delay = 1;
    model_hold  = 5;
    set_req(3);
    wait_ack();
    req_valid[3] = 1'b0;
    wait_resp();
    t_r = cyc;
    checks++;
    if (resp_done !== 4'b1000 || resp_res !== 32'hC1800000)
      $display("FAIL hold_resp: got done=%b res=%h want 1000/c1800000", resp_done, resp_res);
    else passes++;
    set_req(3);
    begin
      int n;
      n = 0;
      while (mul_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    end
    checks++;
    if (cyc - t_r !== 6)
      $display("FAIL hold_restart: got %0d cycles want 6", cyc - t_r);
    else passes++;
    req_valid[3] = 1'b0;
    model_hold   = 0;
    wait_resp();
  endtask

  task automatic test_rst_mid();
    do_reset();
    model_delay = 1;
    set_req(1);
    wait_ack();
    req_valid[1] = 1'b0;
    wait_resp();
    @(negedge clk);
    model_hang = 1'b1;
    set_req(2);
    wait_ack();
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ack, resp_done, resp_err, mul_ready, hung} !== '0)
      $display("FAIL rstmid_ctrl: got %b want 0", {req_ack, resp_done, resp_err, mul_ready, hung});
    else passes++;
    checks++;
    if (resp_res !== '0 || op_count !== '0 || mul_op1 !== '0 || mul_op2 !== '0)
      $display("FAIL rstmid_data: got res=%h cnt=%0d op1=%h op2=%h want all 0", resp_res, op_count, mul_op1, mul_op2);
    else passes++;
    rst        = 1'b0;
    model_hang = 1'b0;
    set_req(1);
    set_req(3);
    wait_ack();
    checks++;
    if (req_ack !== 4'b0010)
      $display("FAIL rstmid_ptr: got %b want 0010", req_ack);
    else passes++;
    req_valid[1] = 1'b0;
    wait_resp();
    checks++;
    if (resp_done !== 4'b0010 || resp_res !== prod_tab[1])
      $display("FAIL rstmid_resp: got done=%b res=%h want 0010/%h", resp_done, resp_res, prod_tab[1]);
    else passes++;
    req_valid[3] = 1'b0;
  endtask

  task automatic test_timeout();
    int t_p;
    bit seen;
    do_reset();
    model_hang = 1'b1;
    set_req(0);
    wait_ack();
    t_p = cyc;
    checks++;
    if (req_ack !== 4'b0001 || mul_ready !== 1'b1)
      $display("FAIL to_ack: got ack=%b rdy=%b want 0001/1", req_ack, mul_ready);
    else passes++;
    req_valid[0] = 1'b0;
    wait_resp();
    checks++;
    if (cyc - t_p !== TIMEOUT + 1)
      $display("FAIL to_latency: got %0d want %0d", cyc - t_p, TIMEOUT + 1);
    else passes++;
    checks++;
    if (resp_done !== 4'b0001 || resp_res !== 32'h7FC00000 || resp_err !== 1'b1)
      $display("FAIL to_resp: got done=%b res=%h err=%b want 0001/7fc00000/1", resp_done, resp_res, resp_err);
    else passes++;
    checks++;
    if (hung !== 1'b1 || op_count !== 16'd0)
      $display("FAIL to_hung: got hung=%b cnt=%0d want 1/0", hung, op_count);
    else passes++;
    @(negedge clk);
    checks++;
    if (resp_done !== '0 || resp_err !== 1'b0 || hung !== 1'b1)
      $display("FAIL to_after: got done=%b err=%b hung=%b want 0000/0/1", resp_done, resp_err, hung);
    else passes++;
    set_req(2);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_ack !== '0 || mul_ready !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || hung !== 1'b1)
      $display("FAIL to_locked: got grant_seen=%b hung=%b want 0/1", seen, hung);
    else passes++;
  endtask

  initial begin : guard
    #200000;
    $display("FAIL sim_timeout: got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    rst       = 1'b1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_all4();
    test_alternate();
    test_done_hold();
    test_rst_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_mul_arbiter
`default_nettype wire
